// File: rtl/ifetch_h_if.sv
// Fetch-stage bus bundle: halfword RAM read port plus decoder-side instruction handshake.
interface ifetch_h_if #(
    parameter int ADDR_WIDTH = 13
);
    logic                  enaA;
    logic [ADDR_WIDTH-1:0] addrA;
    logic [15:0]           doutA;
    logic                  redirect;
    logic [ADDR_WIDTH:0]   redirect_pc;
    logic [31:0]           inst;
    logic [ADDR_WIDTH:0]   inst_pc;
    logic                  inst_rvc;
    logic                  inst_valid;
    logic                  inst_ready;

    modport master (
        output enaA, addrA, inst, inst_pc, inst_rvc, inst_valid,
        input  doutA, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  enaA, addrA, inst, inst_pc, inst_rvc, inst_valid,
        output doutA, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/ifetch_h.sv
// RV32IC fetch/align stage: sequential halfword reads into a 4-entry queue,
// instruction assembly at the head, valid/ready handshake and PC redirect.
module ifetch_h #(
    parameter int                  ADDR_WIDTH = 13,
    parameter logic [ADDR_WIDTH:0] RESET_PC   = '0
) (
    input  logic      clk,
    input  logic      xreset,
    ifetch_h_if.master bus
);
    logic [15:0]           r_qdata [4];
    logic [ADDR_WIDTH-1:0] r_qaddr [4];
    logic [1:0]            r_head;
    logic [1:0]            r_tail;
    logic [2:0]            r_count;

    logic                  r_enaA;
    logic [ADDR_WIDTH-1:0] r_addrA;
    logic [ADDR_WIDTH-1:0] r_fptr;
    logic                  r_infl;
    logic [ADDR_WIDTH-1:0] r_infl_addr;

    logic [15:0] w_hw0;
    logic [15:0] w_hw1;
    logic        w_rvc;
    logic        w_valid;
    logic        w_pop;
    logic [2:0]  w_pop_n;
    logic [2:0]  w_cnt_n;
    logic        w_issue;
    logic        w_unused;

    assign w_unused = bus.redirect_pc[0];

    always_comb begin
        w_hw0   = r_qdata[r_head];
        w_hw1   = r_qdata[r_head + 2'd1];
        w_rvc   = (w_hw0[1:0] != 2'b11);
        w_valid = w_rvc ? (r_count != 3'd0) : (r_count >= 3'd2);
        w_pop   = w_valid & bus.inst_ready & ~bus.redirect;
        w_pop_n = '0;
        if (w_pop) w_pop_n = w_rvc ? 3'd1 : 3'd2;
        w_cnt_n = r_count + {2'b00, r_infl} - w_pop_n;
        // r_enaA is a read whose data lands next cycle, so it already owns a slot
        w_issue = ~bus.redirect & ((w_cnt_n + {2'b00, r_enaA}) < 3'd4);
    end

    always_comb begin
        bus.enaA       = r_enaA;
        bus.addrA      = r_addrA;
        bus.inst_valid = w_valid;
        bus.inst_rvc   = w_valid & w_rvc;
        bus.inst       = '0;
        bus.inst_pc    = '0;
        if (w_valid) begin
            bus.inst    = w_rvc ? {16'h0000, w_hw0} : {w_hw1, w_hw0};
            bus.inst_pc = {r_qaddr[r_head], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                r_qdata[i] <= '0;
                r_qaddr[i] <= '0;
            end
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_enaA      <= 1'b0;
            r_addrA     <= '0;
            r_fptr      <= RESET_PC[ADDR_WIDTH:1];
            r_infl      <= 1'b0;
            r_infl_addr <= '0;
        end else if (bus.redirect) begin
            // Target read is launched straight away; the fetch pointer moves past it
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_infl      <= 1'b0;
            r_enaA      <= 1'b1;
            r_addrA     <= bus.redirect_pc[ADDR_WIDTH:1];
            r_fptr      <= bus.redirect_pc[ADDR_WIDTH:1] + 1'b1;
        end else begin
            if (r_infl) begin
                r_qdata[r_tail] <= bus.doutA;
                r_qaddr[r_tail] <= r_infl_addr;
                r_tail          <= r_tail + 2'd1;
            end
            r_head      <= r_head + w_pop_n[1:0];
            r_count     <= w_cnt_n;
            r_infl      <= r_enaA;
            r_infl_addr <= r_addrA;
            r_enaA      <= w_issue;
            if (w_issue) begin
                r_addrA <= r_fptr;
                r_fptr  <= r_fptr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ifetch_h.sv
// Directed bench for ifetch_h with a one-cycle-latency halfword RAM model.
module tb_ifetch_h;
    localparam int AW = 13;

    logic clk;
    logic xreset;
    int   n_vec;
    int   n_err;
    int   n_pulse;
    logic [AW-1:0] addr_log [4];
    logic [15:0]   mem [0:(1<<AW)-1];

    ifetch_h_if #(.ADDR_WIDTH(AW)) bus ();

    ifetch_h #(.ADDR_WIDTH(AW), .RESET_PC(14'h0000)) dut (
        .clk    (clk),
        .xreset (xreset),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (bus.enaA) bus.doutA <= mem[bus.addrA];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1 xreset = 1'b0;
        #2 xreset = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0000;
        mem[0]      = 16'h4501;
        mem[1]      = 16'h0513;
        mem[2]      = 16'h0000;
        mem[13'h80] = 16'h0001;
        mem[13'h100] = 16'h0002;
        mem[13'h1FFF] = 16'h0013;

        xreset          = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.inst_ready  = 1'b1;
        bus.doutA       = '0;

        // reset state
        #1;
        chk("rst_enaA",  32'(bus.enaA), 32'd0);
        chk("rst_addrA", 32'(bus.addrA), 32'd0);
        chk("rst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_inst",  bus.inst, 32'd0);
        chk("rst_pc",    32'(bus.inst_pc), 32'd0);
        chk("rst_rvc",   32'(bus.inst_rvc), 32'd0);
        @(posedge clk);
        #1 xreset = 1'b1;

        // basic stream: rvc then 32-bit
        step();
        chk("t1_c1_enaA",  32'(bus.enaA), 32'd1);
        chk("t1_c1_addrA", 32'(bus.addrA), 32'd0);
        chk("t1_c1_valid", 32'(bus.inst_valid), 32'd0);
        step();
        chk("t1_c2_addrA", 32'(bus.addrA), 32'd1);
        chk("t1_c2_valid", 32'(bus.inst_valid), 32'd0);
        step();
        chk("t1_c3_valid", 32'(bus.inst_valid), 32'd1);
        chk("t1_c3_inst",  bus.inst, 32'h00004501);
        chk("t1_c3_pc",    32'(bus.inst_pc), 32'd0);
        chk("t1_c3_rvc",   32'(bus.inst_rvc), 32'd1);
        step();
        chk("t1_c4_valid", 32'(bus.inst_valid), 32'd0);
        step();
        chk("t1_c5_valid", 32'(bus.inst_valid), 32'd1);
        chk("t1_c5_inst",  bus.inst, 32'h00000513);
        chk("t1_c5_pc",    32'(bus.inst_pc), 32'd2);
        chk("t1_c5_rvc",   32'(bus.inst_rvc), 32'd0);

        // backpressure: queue fills after exactly 4 reads
        bus.inst_ready = 1'b0;
        reset_pulse();
        n_pulse = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (bus.enaA) begin
                if (n_pulse < 4) addr_log[n_pulse] = bus.addrA;
                n_pulse++;
            end
            if (k == 3) begin
                chk("t2_c3_inst", bus.inst, 32'h00004501);
                chk("t2_c3_pc",   32'(bus.inst_pc), 32'd0);
            end
        end
        chk("t2_pulses", 32'(n_pulse), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("t2_addr%0d", i), 32'(addr_log[i]), 32'(i));
        chk("t2_c10_enaA",  32'(bus.enaA), 32'd0);
        chk("t2_c10_valid", 32'(bus.inst_valid), 32'd1);
        chk("t2_c10_inst",  bus.inst, 32'h00004501);
        chk("t2_c10_pc",    32'(bus.inst_pc), 32'd0);

        // redirect with reads in flight
        reset_pulse();
        step();
        step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 14'h0100;
        step();
        bus.redirect = 1'b0;
        chk("t3_n1_enaA",  32'(bus.enaA), 32'd1);
        chk("t3_n1_addrA", 32'(bus.addrA), 32'h80);
        chk("t3_n1_valid", 32'(bus.inst_valid), 32'd0);
        step();
        chk("t3_n2_valid", 32'(bus.inst_valid), 32'd0);
        step();
        chk("t3_n3_valid", 32'(bus.inst_valid), 32'd1);
        chk("t3_n3_inst",  bus.inst, 32'h00000001);
        chk("t3_n3_pc",    32'(bus.inst_pc), 32'h100);
        chk("t3_n3_rvc",   32'(bus.inst_rvc), 32'd1);
        bus.inst_ready = 1'b1;
        step();
        chk("t3_n4_valid", 32'(bus.inst_valid), 32'd1);
        chk("t3_n4_pc",    32'(bus.inst_pc), 32'h102);

        // redirect beats a simultaneous handshake
        step();
        chk("t4_n_valid", 32'(bus.inst_valid), 32'd1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 14'h0200;
        step();
        bus.redirect = 1'b0;
        chk("t4_n1_addrA", 32'(bus.addrA), 32'h100);
        chk("t4_n1_valid", 32'(bus.inst_valid), 32'd0);
        step();
        step();
        chk("t4_n3_valid", 32'(bus.inst_valid), 32'd1);
        chk("t4_n3_pc",    32'(bus.inst_pc), 32'h200);
        chk("t4_n3_inst",  bus.inst, 32'h00000002);

        // 32-bit instruction straddling the top of memory
        mem[0] = 16'h0000;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 14'h3FFE;
        step();
        bus.redirect = 1'b0;
        chk("t5_n1_addrA", 32'(bus.addrA), 32'h1FFF);
        step();
        chk("t5_n2_enaA",  32'(bus.enaA), 32'd1);
        chk("t5_n2_addrA", 32'(bus.addrA), 32'h0000);
        step();
        chk("t5_n3_valid", 32'(bus.inst_valid), 32'd0);
        step();
        chk("t5_n4_valid", 32'(bus.inst_valid), 32'd1);
        chk("t5_n4_inst",  bus.inst, 32'h00000013);
        chk("t5_n4_pc",    32'(bus.inst_pc), 32'h3FFE);
        chk("t5_n4_rvc",   32'(bus.inst_rvc), 32'd0);

        // short asynchronous reset pulse mid-stream
        step();
        step();
        chk("t6_pre_enaA", 32'(bus.enaA), 32'd1);
        #1 xreset = 1'b0;
        #1;
        chk("t6_async_enaA",  32'(bus.enaA), 32'd0);
        chk("t6_async_valid", 32'(bus.inst_valid), 32'd0);
        chk("t6_async_addrA", 32'(bus.addrA), 32'd0);
        #1 xreset = 1'b1;
        step();
        chk("t6_c1_enaA",  32'(bus.enaA), 32'd1);
        chk("t6_c1_addrA", 32'(bus.addrA), 32'd0);
        step();
        step();
        chk("t6_c3_valid", 32'(bus.inst_valid), 32'd1);
        chk("t6_c3_pc",    32'(bus.inst_pc), 32'd0);
        chk("t6_c3_inst",  bus.inst, 32'h00000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
